// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA raster timing generator.
//   - 640x480@60 timing constants used as the top-level defaults.
//   - calc_total(): sums the four regions of one axis into its total period.
//   - RGB444 colours and bar_colour() for the optional colour-bar pattern.
package vga_pkg;

    localparam int VGA_CLK_DIV  = 4;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam logic [11:0] RGB_WHITE   = 12'hFFF;
    localparam logic [11:0] RGB_YELLOW  = 12'hFF0;
    localparam logic [11:0] RGB_CYAN    = 12'h0FF;
    localparam logic [11:0] RGB_GREEN   = 12'h0F0;
    localparam logic [11:0] RGB_MAGENTA = 12'hF0F;
    localparam logic [11:0] RGB_RED     = 12'hF00;
    localparam logic [11:0] RGB_BLUE    = 12'h00F;
    localparam logic [11:0] RGB_BLACK   = 12'h000;

    // Total period of one axis: active + front porch + sync + back porch.
    function automatic int calc_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Colour of bar idx, left to right.
    function automatic logic [11:0] bar_colour(input logic [2:0] idx);
        logic [11:0] c;
        case (idx)
            3'd0:    c = RGB_WHITE;
            3'd1:    c = RGB_YELLOW;
            3'd2:    c = RGB_CYAN;
            3'd3:    c = RGB_GREEN;
            3'd4:    c = RGB_MAGENTA;
            3'd5:    c = RGB_RED;
            3'd6:    c = RGB_BLUE;
            3'd7:    c = RGB_BLACK;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_pix_div.sv
// vga_pix_div: divides the system clock into a one-clock pixel strobe.
//   clk_i      system clock
//   rst_ni     synchronous active-low reset
//   pix_tick_o high on the last system clock of each pixel period
// The strobe is gated by rst_ni so it stays low while reset is applied even
// when CLK_DIV=1, and is high on the very first clock after release then.
module vga_pix_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic pix_tick_o
);

    localparam int              DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;

    // Next divider value: wrap after the last phase.
    always_comb begin
        div_d = div_q;
        if (div_q == DIV_LAST) begin
            div_d = {DW{1'b0}};
        end else begin
            div_d = div_q + DW'(1'b1);
        end
    end

    // Divider phase register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            div_q <= {DW{1'b0}};
        end else begin
            div_q <= div_d;
        end
    end

    assign pix_tick_o = rst_ni && (div_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
//   clk, rst_n           single clock, synchronous active-low reset
//   rgb_in               colour for the pixel at x/y shown this pixel period
//   pix_tick             one-clock pulse per pixel
//   x, y                 raster position (0..H_TOTAL-1, 0..V_TOTAL-1)
//   line_start           pulse on the tick where x wraps to 0
//   frame_start          pulse on the tick where x and y both wrap to 0
//   hs, vs, de, rgb_out  registered sync/enable/blanked colour, one pixel
//                        period behind x/y
// Optional macro VGA_TEST_PATTERN_EN adds input test_mode, which replaces
// rgb_in with eight vertical colour bars across the active width.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   CLK_DIV  = VGA_CLK_DIV,
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CW       = 12
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef VGA_TEST_PATTERN_EN
    input  logic          test_mode,
`endif
    input  logic [11:0]   rgb_in,
    output logic          pix_tick,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic          hs,
    output logic          vs,
    output logic          de,
    output logic [11:0]   rgb_out
);

    localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CW-1:0] X_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] Y_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] X_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] Y_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic          tick_s;
    logic          x_last_s;
    logic          y_last_s;
    logic          hs_raw_s;
    logic          vs_raw_s;
    logic          de_raw_s;
    logic [11:0]   pix_rgb_s;

    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          de_q, de_d;
    logic [11:0]   rgb_q, rgb_d;

    vga_pix_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_div (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .pix_tick_o (tick_s)
    );

    assign x_last_s = (x_q == X_LAST);
    assign y_last_s = (y_q == Y_LAST);
    assign hs_raw_s = (x_q >= HS_START) && (x_q < HS_END);
    assign vs_raw_s = (y_q >= VS_START) && (y_q < VS_END);
    assign de_raw_s = (x_q < X_ACT) && (y_q < Y_ACT);

`ifdef VGA_TEST_PATTERN_EN
    // Bar index tracks x by counting pixels per bar, restarting at x=0.
    localparam logic [CW-1:0] BAR_LAST = CW'(H_ACTIVE / 8 - 1);

    logic [CW-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]    bar_idx_q, bar_idx_d;

    // Next bar position, aligned with the next x.
    always_comb begin
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        if (tick_s) begin
            if (x_last_s) begin
                bar_cnt_d = {CW{1'b0}};
                bar_idx_d = 3'd0;
            end else if (bar_cnt_q == BAR_LAST) begin
                bar_cnt_d = {CW{1'b0}};
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_cnt_d = bar_cnt_q + CW'(1'b1);
            end
        end else begin
            bar_cnt_d = bar_cnt_q;
        end
    end

    // Bar position registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bar_cnt_q <= {CW{1'b0}};
            bar_idx_q <= 3'd0;
        end else begin
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
        end
    end

    assign pix_rgb_s = test_mode ? bar_colour(bar_idx_q) : rgb_in;
`else
    assign pix_rgb_s = rgb_in;
`endif

    // Raster position: x and y move together on the wrap tick.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (tick_s) begin
            if (x_last_s) begin
                x_d = {CW{1'b0}};
                if (y_last_s) begin
                    y_d = {CW{1'b0}};
                end else begin
                    y_d = y_q + CW'(1'b1);
                end
            end else begin
                x_d = x_q + CW'(1'b1);
            end
        end else begin
            x_d = x_q;
        end
    end

    // Output stage samples the current pixel's decode once per pixel.
    always_comb begin
        hs_d  = hs_q;
        vs_d  = vs_q;
        de_d  = de_q;
        rgb_d = rgb_q;
        if (tick_s) begin
            hs_d  = hs_raw_s ? HS_POL : ~HS_POL;
            vs_d  = vs_raw_s ? VS_POL : ~VS_POL;
            de_d  = de_raw_s;
            rgb_d = de_raw_s ? pix_rgb_s : 12'h000;
        end else begin
            rgb_d = rgb_q;
        end
    end

    // Position and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q   <= {CW{1'b0}};
            y_q   <= {CW{1'b0}};
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            de_q  <= 1'b0;
            rgb_q <= 12'h000;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            de_q  <= de_d;
            rgb_q <= rgb_d;
        end
    end

    assign pix_tick    = tick_s;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = tick_s && x_last_s;
    assign frame_start = tick_s && x_last_s && y_last_s;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign de          = de_q;
    assign rgb_out     = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: u0 uses the 640x480 defaults, u1 is a tiny raster
// (CLK_DIV=1, 14x8 total, active-high syncs) so whole frames fit in a short run.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0_n, rst1_n, tm;
    logic [11:0] rgb0, rgb1;

    logic        tick0, ls0, fs0, hs0, vs0, de0;
    logic [11:0] x0, y0, rgbo0;
    logic        tick1, ls1, fs1, hs1, vs1, de1;
    logic [11:0] x1, y1, rgbo1;

    int checks = 0;
    int errors = 0;

    vga_timing_gen u0 (
        .clk (clk), .rst_n (rst0_n),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode (tm),
`endif
        .rgb_in (rgb0), .pix_tick (tick0), .x (x0), .y (y0),
        .line_start (ls0), .frame_start (fs0), .hs (hs0), .vs (vs0),
        .de (de0), .rgb_out (rgbo0)
    );

    vga_timing_gen #(
        .CLK_DIV (1), .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (1),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .HS_POL (1'b1), .VS_POL (1'b1), .CW (12)
    ) u1 (
        .clk (clk), .rst_n (rst1_n),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode (tm),
`endif
        .rgb_in (rgb1), .pix_tick (tick1), .x (x1), .y (y1),
        .line_start (ls1), .frame_start (fs1), .hs (hs1), .vs (vs1),
        .de (de1), .rgb_out (rgbo1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    initial begin
        int n;
        int hs_cnt, de_cnt, vs_cnt, blank_bad, rgb_bad, ybad, ls_cnt, fs_cnt;
        int first_ev, second_ev;

        rst0_n = 1'b0; rst1_n = 1'b0; tm = 1'b0;
        rgb0 = 12'hABC; rgb1 = 12'hFFF;
        repeat (3) @(negedge clk);

        // Reset values.
        chk("rst_hs", hs0, 1);      chk("rst_vs", vs0, 1);
        chk("rst_de", de0, 0);      chk("rst_rgb", rgbo0, 0);
        chk("rst_x", x0, 0);        chk("rst_y", y0, 0);
        chk("rst_tick", tick0, 0);
        chk("rst_hs_pol1", hs1, 0); chk("rst_vs_pol1", vs1, 0);
        chk("rst_tick_div1", tick1, 0);

        // Release: first tick after 3 clocks, de after 4.
        rst0_n = 1'b1;
        @(negedge clk);
        chk("no_tick_div1", tick0, 0);
        repeat (2) @(negedge clk);
        chk("first_tick", tick0, 1);
        chk("de_before_first_tick", de0, 0);
        @(negedge clk);
        chk("de_rise", de0, 1);
        chk("rgb_first", rgbo0, 12'hABC);
        chk("x_after_first_tick", x0, 1);

        // hs falls the tick after x=656 is presented.
        n = 0;
        while (!(tick0 === 1'b1 && x0 == 12'd656) && n < 4000) begin
            @(negedge clk); n++;
        end
        chk("reach_x656", (n < 4000), 1);
        chk("hs_before_sync", hs0, 1);
        @(negedge clk);
        chk("hs_sync_start", hs0, 0);
        chk("x_at_657", x0, 657);

        // Two full lines with white input.
        rgb0 = 12'hFFF;
        hs_cnt = 0; de_cnt = 0; blank_bad = 0; rgb_bad = 0;
        first_ev = -1; second_ev = -1;
        for (int c = 0; c < 6400; c++) begin
            if (tick0) begin
                if (!hs0) hs_cnt++;
                if (de0) de_cnt++;
            end
            if (ls0) begin
                if (first_ev < 0) first_ev = c;
                else if (second_ev < 0) second_ev = c;
            end
            if (!de0 && rgbo0 != 12'h000) blank_bad++;
            if (de0 && rgbo0 != 12'hFFF) rgb_bad++;
            @(negedge clk);
        end
        chk("hs_low_ticks", hs_cnt, 192);
        chk("de_high_ticks", de_cnt, 1280);
        chk("line_period", second_ev - first_ev, 3200);
        chk("blank_violations", blank_bad, 0);
        chk("active_rgb_bad", rgb_bad, 0);
        chk("x_after_lines", x0, 657);
        chk("y_after_lines", y0, 2);
        chk("vs_idle", vs0, 1);

        // Mid-frame reset for one clock at x=300.
        n = 0;
        while (x0 != 12'd300 && n < 4000) begin
            @(negedge clk); n++;
        end
        chk("reach_x300", (n < 4000), 1);
        rst0_n = 1'b0;
        @(negedge clk);
        rst0_n = 1'b1;
        chk("mid_rst_x", x0, 0);    chk("mid_rst_y", y0, 0);
        chk("mid_rst_hs", hs0, 1);  chk("mid_rst_vs", vs0, 1);
        chk("mid_rst_de", de0, 0);  chk("mid_rst_rgb", rgbo0, 0);
        chk("mid_rst_tick", tick0, 0);
        repeat (4) @(negedge clk);
        chk("restart_de", de0, 1);
        chk("restart_x", x0, 1);

        // Small raster, CLK_DIV=1: de after one clock, tick constant.
        rst1_n = 1'b1;
        @(negedge clk);
        chk("div1_tick", tick1, 1);
        chk("div1_de", de1, 1);
        chk("div1_x", x1, 1);
        chk("div1_hs_idle", hs1, 0);
        chk("div1_rgb", rgbo1, 12'hFFF);

        // Two full frames of the small raster.
        hs_cnt = 0; de_cnt = 0; vs_cnt = 0; blank_bad = 0; ybad = 0;
        ls_cnt = 0; fs_cnt = 0; first_ev = -1; second_ev = -1;
        for (int c = 0; c < 224; c++) begin
            if (!tick1) blank_bad++;
            if (hs1) hs_cnt++;
            if (vs1) vs_cnt++;
            if (de1) de_cnt++;
            if (ls1) ls_cnt++;
            if (y1 > 12'd7) ybad++;
            if (!de1 && rgbo1 != 12'h000) blank_bad++;
            if (fs1) begin
                fs_cnt++;
                if (first_ev < 0) first_ev = c;
                else if (second_ev < 0) second_ev = c;
            end
            @(negedge clk);
        end
        chk("s_hs_high", hs_cnt, 48);
        chk("s_vs_high", vs_cnt, 56);
        chk("s_de_high", de_cnt, 64);
        chk("s_line_starts", ls_cnt, 16);
        chk("s_frame_starts", fs_cnt, 2);
        chk("s_frame_period", second_ev - first_ev, 112);
        chk("s_y_range", ybad, 0);
        chk("s_blank_and_tick", blank_bad, 0);

`ifdef VGA_TEST_PATTERN_EN
        // One-pixel-wide bars on the small raster.
        tm = 1'b1;
        rgb1 = 12'h123;
        n = 0;
        while (!(x1 == 12'd0 && y1 == 12'd0) && n < 200) begin
            @(negedge clk); n++;
        end
        chk("tp_reach_origin", (n < 200), 1);
        @(negedge clk);
        chk("tp_bar_white", rgbo1, 12'hFFF);
        @(negedge clk);
        chk("tp_bar_yellow", rgbo1, 12'hFF0);
        @(negedge clk);
        chk("tp_bar_cyan", rgbo1, 12'h0FF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
